// File: rtl/dnn_sched_pkg.sv
// Shared types and constants for the MNIST frame scheduler.
package dnn_sched_pkg;

  localparam int N_OUT = 10;
  localparam int CLASS_W = 4;
  localparam logic [CLASS_W-1:0] ERR_CLASS = 4'hF;

  typedef enum logic [2:0] {
    S_LOAD,
    S_BIAS,
    S_KICK,
    S_RUN,
    S_ARGMAX,
    S_RESULT
  } sched_state_t;

endpackage

// File: rtl/dnn_argmax_seq.sv
// Serial signed arg-max over the ten engine outputs, one entry per cycle.
module dnn_argmax_seq
  import dnn_sched_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [N_OUT-1:0][7:0]   vals,
  output logic                    done,
  output logic [CLASS_W-1:0]      best_idx,
  output logic signed [7:0]       best_val
);

  logic               active;
  logic [CLASS_W-1:0] cnt;
  logic signed [7:0]  cur;

  always_comb begin
    cur = '0;
    for (int unsigned i = 0; i < N_OUT; i++) begin
      if (cnt == CLASS_W'(i)) cur = vals[i];
    end
  end

  assign done = active && (cnt == CLASS_W'(N_OUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active   <= 1'b0;
      cnt      <= '0;
      best_idx <= '0;
      best_val <= '0;
    end else if (start) begin
      active <= 1'b1;
      cnt    <= '0;
    end else if (active) begin
      // Strict compare keeps the lowest index on ties.
      if (cnt == '0 || cur > best_val) begin
        best_val <= cur;
        best_idx <= cnt;
      end
      if (done) active <= 1'b0;
      else      cnt    <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dnn_frame_sched.sv
// Frame scheduler: load pixels + bias, kick engine, arg-max, return class.
// Optional engine watchdog enabled by defining DNN_SCHED_WDOG_EN.
module dnn_frame_sched
  import dnn_sched_pkg::*;
#(
  parameter int                     ADDR_WIDTH  = 16,
  parameter logic [ADDR_WIDTH-1:0]  ADDR_BASE_A = 16'h0000,
  parameter int                     N_PIX       = 400,
  parameter logic signed [7:0]      A_BIAS_VAL  = 8'sh7F,
  parameter logic [31:0]            WDOG_CYCLES = 32'd200000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    pix_valid,
  output logic                    pix_ready,
  input  logic [7:0]              pix_data,
  output logic                    wr_en,
  output logic [ADDR_WIDTH-1:0]   wr_addr,
  output logic [7:0]              wr_data,
  output logic                    eng_reset,
  output logic                    eng_start,
  input  logic                    eng_done,
  input  logic [N_OUT-1:0][7:0]   eng_out,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [CLASS_W-1:0]      res_class,
  output logic [7:0]              res_score,
  output logic                    res_err,
  output logic                    busy
);

  localparam int IDX_W = $clog2(N_PIX);

  sched_state_t       state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               kick_ph_q, kick_ph_d;
  logic               pix_ready_q;
  logic               pix_hs;
  logic               am_start, am_done;
  logic [CLASS_W-1:0] am_idx;
  logic signed [7:0]  am_val;
  logic               wdog_trip;
  logic               err_q;

`ifdef DNN_SCHED_WDOG_EN
  logic [31:0] wdog_q;
`endif

  // pix_ready is registered from the next state so it reads 0 during reset.
  assign pix_hs = pix_valid && pix_ready_q;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    kick_ph_d = kick_ph_q;
    am_start  = 1'b0;
    wdog_trip = 1'b0;
    case (state_q)
      S_LOAD: begin
        if (pix_hs) begin
          if (idx_q == IDX_W'(N_PIX - 1)) state_d = S_BIAS;
          else                            idx_d   = idx_q + 1'b1;
        end
      end
      S_BIAS: begin
        state_d   = S_KICK;
        kick_ph_d = 1'b0;
      end
      S_KICK: begin
        if (kick_ph_q) state_d   = S_RUN;
        else           kick_ph_d = 1'b1;
      end
      S_RUN: begin
        if (eng_done) begin
          am_start = 1'b1;
          state_d  = S_ARGMAX;
        end
`ifdef DNN_SCHED_WDOG_EN
        else if (wdog_q == WDOG_CYCLES - 32'd1) begin
          wdog_trip = 1'b1;
          state_d   = S_RESULT;
        end
`endif
      end
      S_ARGMAX: begin
        if (am_done) state_d = S_RESULT;
      end
      S_RESULT: begin
        if (res_ready) begin
          state_d = S_LOAD;
          idx_d   = '0;
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_LOAD;
      idx_q       <= '0;
      kick_ph_q   <= 1'b0;
      pix_ready_q <= 1'b0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      eng_reset   <= 1'b0;
      eng_start   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      kick_ph_q   <= kick_ph_d;
      pix_ready_q <= (state_d == S_LOAD);
      eng_reset   <= (state_q == S_KICK) && !kick_ph_q;
      eng_start   <= (state_q == S_KICK) && kick_ph_q;
      wr_en       <= 1'b0;
      if (pix_hs) begin
        wr_en   <= 1'b1;
        wr_addr <= ADDR_BASE_A + ADDR_WIDTH'(idx_q);
        wr_data <= pix_data;
      end else if (state_q == S_BIAS) begin
        wr_en   <= 1'b1;
        wr_addr <= ADDR_BASE_A + ADDR_WIDTH'(N_PIX);
        wr_data <= A_BIAS_VAL;
      end
    end
  end

`ifdef DNN_SCHED_WDOG_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdog_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wdog_q <= (state_q == S_RUN) ? wdog_q + 32'd1 : '0;
      if (wdog_trip)                              err_q <= 1'b1;
      else if (state_q == S_RESULT && res_ready)  err_q <= 1'b0;
    end
  end
`else
  logic wdog_unused;
  assign wdog_unused = ^WDOG_CYCLES;
  assign err_q       = 1'b0;
`endif

  dnn_argmax_seq u_argmax (
    .clk      (clk),
    .rst_n    (rst),
    .start    (am_start),
    .vals     (eng_out),
    .done     (am_done),
    .best_idx (am_idx),
    .best_val (am_val)
  );

  assign pix_ready = pix_ready_q;
  assign res_valid = (state_q == S_RESULT);
  assign res_class = err_q ? ERR_CLASS : am_idx;
  assign res_score = err_q ? '0 : am_val;
  assign res_err   = err_q;
  assign busy      = !(state_q == S_LOAD && idx_q == '0);

endmodule
